// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave pipelined Wishbone B4 arbiter with round-robin grants,
// outstanding-request limiting and a hung-cycle timeout that errors the owner.
module wb_arbiter_2m #(
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_stall_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_stall_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_stall_i,
  output logic [1:0]  grant_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]    MAX_O  = 4'(MAX_OUTST);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          last_reg, last_next;
  logic [3:0]    outst_reg, outst_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          abort_err_reg, abort_err_next;
  logic          winner;

  logic [1:0]  cyc_v, stb_v, we_v, ack_v, err_v, stall_v;
  logic [31:0] addr_v [2];
  logic [31:0] wdat_v [2];
  logic [3:0]  sel_v  [2];

  assign cyc_v     = {m1_cyc_i, m0_cyc_i};
  assign stb_v     = {m1_stb_i, m0_stb_i};
  assign we_v      = {m1_we_i, m0_we_i};
  assign addr_v[0] = m0_addr_i;
  assign addr_v[1] = m1_addr_i;
  assign wdat_v[0] = m0_data_i;
  assign wdat_v[1] = m1_data_i;
  assign sel_v[0]  = m0_sel_i;
  assign sel_v[1]  = m1_sel_i;

  logic granted, own_cyc, outst_nz, at_limit, resp, accept, dec, counting, expire;

  assign granted  = (state_reg == GNT0) || (state_reg == GNT1);
  assign own_cyc  = cyc_v[owner_reg];
  assign outst_nz = (outst_reg != 4'd0);
  assign at_limit = !(outst_reg < MAX_O);
  assign resp     = s_ack_i | s_err_i;
  assign accept   = s_stb_o & !s_stall_i;
  assign dec      = resp & outst_nz;
  assign counting = granted & outst_nz & !resp;
  assign expire   = (TIMEOUT != 0) && counting && (timer_reg == T_LAST);

  // Slave side follows the owner combinationally so the first stb goes out
  // in the first granted cycle.
  assign s_cyc_o  = granted & own_cyc;
  assign s_stb_o  = granted & own_cyc & stb_v[owner_reg] & !at_limit;
  assign s_we_o   = granted & we_v[owner_reg];
  assign s_addr_o = granted ? addr_v[owner_reg] : '0;
  assign s_data_o = granted ? wdat_v[owner_reg] : '0;
  assign s_sel_o  = granted ? sel_v[owner_reg]  : '0;
  assign grant_o  = (state_reg == IDLE) ? 2'b00 : (owner_reg ? 2'b10 : 2'b01);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic is_owner;
      assign is_owner    = (owner_reg == 1'(gi));
      assign ack_v[gi]   = granted & is_owner & outst_nz & s_ack_i;
      assign err_v[gi]   = (granted & is_owner & outst_nz & s_err_i) |
                           ((state_reg == ABORT) & is_owner & abort_err_reg);
      assign stall_v[gi] = !(granted & is_owner) | s_stall_i | at_limit;
    end
  endgenerate

  assign m0_data_o  = s_data_i;
  assign m1_data_o  = s_data_i;
  assign m0_ack_o   = ack_v[0];
  assign m1_ack_o   = ack_v[1];
  assign m0_err_o   = err_v[0];
  assign m1_err_o   = err_v[1];
  assign m0_stall_o = stall_v[0];
  assign m1_stall_o = stall_v[1];

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    outst_next     = outst_reg;
    timer_next     = '0;
    abort_err_next = 1'b0;
    winner         = 1'b0;
    unique case (state_reg)
      IDLE: begin
        outst_next = '0;
        if (cyc_v != 2'b00) begin
          winner     = (cyc_v == 2'b11) ? !last_reg : cyc_v[1];
          owner_next = winner;
          last_next  = winner;
          state_next = winner ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_next = IDLE;
          outst_next = '0;
        end else if (expire) begin
          state_next     = ABORT;
          outst_next     = '0;
          abort_err_next = 1'b1;
        end else begin
          unique case ({accept, dec})
            2'b10:   outst_next = outst_reg + 4'd1;
            2'b01:   outst_next = outst_reg - 4'd1;
            default: outst_next = outst_reg;
          endcase
          timer_next = counting ? timer_reg + TW'(1) : '0;
        end
      end
      ABORT: begin
        outst_next = '0;
        if (!own_cyc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      outst_reg     <= '0;
      timer_reg     <= '0;
      abort_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      outst_reg     <= outst_next;
      timer_reg     <= timer_next;
      abort_err_reg <= abort_err_next;
    end
  end

endmodule
